// File: rtl/free_list_if.sv
// Rename-stage bundle between dispatch/retire/recovery and the physical-register free list.
// Requests flow master->slave; grants, counts and the error flag flow back combinationally.
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif

interface free_list_if #(
    parameter int NUM_PR = 64,
    parameter int TAG_W  = `SYS_PHYS_REG
);
    localparam int DEPTH = NUM_PR - 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   fch_rec_enable;
    logic [2:0]             dispatch_alloc_en;
    logic [2:0]             retire_free_en;
    logic [2:0][TAG_W-1:0]  retire_old_tags;
    logic [2:0][TAG_W-1:0]  dispatch_pr_alloc_tags;
    logic [2:0]             fl_alloc_ok;
    logic [1:0]             fl_avail_cnt;
    logic [CNT_W-1:0]       fl_count;
    logic                   fl_err;

    modport master (
        output fch_rec_enable, dispatch_alloc_en, retire_free_en, retire_old_tags,
        input  dispatch_pr_alloc_tags, fl_alloc_ok, fl_avail_cnt, fl_count, fl_err
    );

    modport slave (
        input  fch_rec_enable, dispatch_alloc_en, retire_free_en, retire_old_tags,
        output dispatch_pr_alloc_tags, fl_alloc_ok, fl_avail_cnt, fl_count, fl_err
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical tags: 3-lane zero-latency allocate, 3-lane compacted free.
// No backpressure: ungranted lanes simply see ok=0; overflowing frees are dropped and flagged.
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif

module free_list #(
    parameter int NUM_PR = 64,
    parameter int TAG_W  = `SYS_PHYS_REG
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave fl
);
    localparam int DEPTH  = NUM_PR - 32;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SUM_W  = CNT_W + 2;
    localparam int PSUM_W = PTR_W + 3;

    logic [TAG_W-1:0] entries_q [DEPTH];
    logic [TAG_W-1:0] entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [2:0]       n_alloc;
    logic [2:0]       n_free;
    logic [2:0]       w_idx;
    logic [SUM_W-1:0] next_cnt;
    logic             ovf;

    // Modulo works for any DEPTH, including non-power-of-two rings.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [2:0] n);
        logic [PSUM_W-1:0] s;
        s = PSUM_W'(p) + PSUM_W'(n);
        s = s % PSUM_W'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        n_alloc                   = '0;
        fl.fl_alloc_ok            = '0;
        fl.dispatch_pr_alloc_tags = '0;
        for (int i = 0; i < 3; i++) begin
            if (fl.dispatch_alloc_en[i] && (SUM_W'(n_alloc) < SUM_W'(count_q))) begin
                fl.fl_alloc_ok[i]            = 1'b1;
                fl.dispatch_pr_alloc_tags[i] = entries_q[ptr_add(head_q, n_alloc)];
                n_alloc                      = n_alloc + 3'd1;
            end
        end
    end

    assign fl.fl_count     = count_q;
    assign fl.fl_err       = err_q;
    assign fl.fl_avail_cnt = (SUM_W'(count_q) >= SUM_W'(3)) ? 2'd3 : 2'(count_q);

    always_comb begin
        entries_d = entries_q;
        n_free    = '0;
        w_idx     = '0;
        for (int i = 0; i < 3; i++) begin
            n_free = n_free + {2'b0, fl.retire_free_en[i]};
        end
        next_cnt = SUM_W'(count_q) - SUM_W'(n_alloc) + SUM_W'(n_free);
        ovf      = next_cnt > SUM_W'(DEPTH);

        tail_d = tail_q;
        if (!ovf) begin
            for (int i = 0; i < 3; i++) begin
                if (fl.retire_free_en[i]) begin
                    entries_d[ptr_add(tail_q, w_idx)] = fl.retire_old_tags[i];
                    w_idx                             = w_idx + 3'd1;
                end
            end
            tail_d = ptr_add(tail_q, n_free);
        end

        head_d  = ptr_add(head_q, n_alloc);
        count_d = ovf ? CNT_W'(SUM_W'(count_q) - SUM_W'(n_alloc)) : CNT_W'(next_cnt);
        err_d   = err_q | ovf;

        // Recovery keeps this cycle's frees, then frees everything not architecturally held.
        if (fl.fch_rec_enable) begin
            head_d  = tail_d;
            count_d = CNT_W'(DEPTH);
        end

        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = TAG_W'(32 + i);
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_W'(DEPTH);
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
        head_q    <= head_d;
        tail_q    <= tail_d;
        count_q   <= count_d;
        err_q     <= err_d;
    end
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: vector table, directed corner sequences, random traffic.
module tb_free_list;
    localparam int NUM_PR = 64;
    localparam int TAG_W  = 6;
    localparam int DEPTH  = NUM_PR - 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    free_list_if #(.NUM_PR(NUM_PR), .TAG_W(TAG_W)) bus();
    free_list #(.NUM_PR(NUM_PR), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .fl(bus));

    int total = 0;
    int bad   = 0;

    int m_ent [DEPTH];
    int m_head, m_tail, m_cnt;
    bit m_err;

    typedef struct {
        logic [2:0] ok;
        int         tag [3];
        int         avail;
        int         cnt;
        bit         err;
    } exp_t;
    exp_t sb [$];

    logic [2:0] s_ok;
    int         s_tag [3];
    int         s_avail, s_cnt;
    bit         s_err;

    typedef struct {
        logic [2:0] a;
        logic [2:0] f;
        int         t0, t1, t2;
        bit         rc;
        logic [2:0] eok;
        int         e0, e1, e2;
        int         ecnt;
        int         eavail;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ent[i] = 32 + i;
        m_head = 0;
        m_tail = 0;
        m_cnt  = DEPTH;
        m_err  = 1'b0;
    endtask

    // One cycle: drive at negedge, predict and compare outputs, then advance the model at posedge.
    task automatic step(input logic [2:0] a, input logic [2:0] f, input int t0, input int t1,
                        input int t2, input bit rc, input bit rs);
        exp_t e, got;
        int   k, nf, nc, w;
        int   ft [3];
        @(negedge clk);
        bus.dispatch_alloc_en  = a;
        bus.retire_free_en     = f;
        bus.retire_old_tags[0] = TAG_W'(t0);
        bus.retire_old_tags[1] = TAG_W'(t1);
        bus.retire_old_tags[2] = TAG_W'(t2);
        bus.fch_rec_enable     = rc;
        rst                    = rs;
        #1;
        e.ok = '0;
        k    = 0;
        for (int i = 0; i < 3; i++) begin
            e.tag[i] = 0;
            if (a[i] && k < m_cnt) begin
                e.ok[i]  = 1'b1;
                e.tag[i] = m_ent[(m_head + k) % DEPTH];
                k++;
            end
        end
        e.avail = (m_cnt >= 3) ? 3 : m_cnt;
        e.cnt   = m_cnt;
        e.err   = m_err;
        sb.push_back(e);

        s_ok = bus.fl_alloc_ok;
        for (int i = 0; i < 3; i++) s_tag[i] = int'(bus.dispatch_pr_alloc_tags[i]);
        s_avail = int'(bus.fl_avail_cnt);
        s_cnt   = int'(bus.fl_count);
        s_err   = bus.fl_err;
        got = sb.pop_front();
        chk("alloc_ok", int'(s_ok), int'(got.ok));
        for (int i = 0; i < 3; i++) chk($sformatf("tag%0d", i), s_tag[i], got.tag[i]);
        chk("avail_cnt", s_avail, got.avail);
        chk("count", s_cnt, got.cnt);
        chk("err", int'(s_err), int'(got.err));

        ft[0] = t0; ft[1] = t1; ft[2] = t2;
        nf = int'(f[0]) + int'(f[1]) + int'(f[2]);
        nc = m_cnt - k + nf;
        if (rs) begin
            model_reset();
        end else begin
            if (nc > DEPTH) begin
                m_err = 1'b1;
                m_cnt = m_cnt - k;
            end else begin
                w = 0;
                for (int i = 0; i < 3; i++) begin
                    if (f[i]) begin
                        m_ent[(m_tail + w) % DEPTH] = ft[i];
                        w++;
                    end
                end
                m_tail = (m_tail + w) % DEPTH;
                m_cnt  = nc;
            end
            m_head = (m_head + k) % DEPTH;
            if (rc) begin
                m_head = m_tail;
                m_cnt  = DEPTH;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        int       guard;
        logic [2:0] ra, rf;

        vt[0] = '{3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000,  0,  0,  0, 32, 3};
        vt[1] = '{3'b111, 3'b000, 0, 0, 0, 1'b0, 3'b111, 32, 33, 34, 32, 3};
        vt[2] = '{3'b101, 3'b000, 0, 0, 0, 1'b0, 3'b101, 35,  0, 36, 29, 3};
        vt[3] = '{3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000,  0,  0,  0, 27, 3};

        bus.dispatch_alloc_en = '0;
        bus.retire_free_en    = '0;
        bus.retire_old_tags   = '0;
        bus.fch_rec_enable    = 1'b0;
        rst                   = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        for (int r = 0; r < 4; r++) begin
            step(vt[r].a, vt[r].f, vt[r].t0, vt[r].t1, vt[r].t2, vt[r].rc, 1'b0);
            chk($sformatf("vec%0d_ok", r), int'(s_ok), int'(vt[r].eok));
            chk($sformatf("vec%0d_tag0", r), s_tag[0], vt[r].e0);
            chk($sformatf("vec%0d_tag1", r), s_tag[1], vt[r].e1);
            chk($sformatf("vec%0d_tag2", r), s_tag[2], vt[r].e2);
            chk($sformatf("vec%0d_cnt", r), s_cnt, vt[r].ecnt);
            chk($sformatf("vec%0d_avail", r), s_avail, vt[r].eavail);
        end

        // Drain to a single free entry, then exhaust it.
        guard = 0;
        while (m_cnt > 1 && guard < 40) begin
            step((m_cnt >= 4) ? 3'b111 : ((m_cnt == 3) ? 3'b011 : 3'b001), 3'b000, 0, 0, 0, 1'b0, 1'b0);
            guard++;
        end
        step(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("last_cnt", s_cnt, 1);
        chk("last_ok", int'(s_ok), 1);
        chk("last_avail", s_avail, 1);
        chk("last_tag", s_tag[0], 63);
        step(3'b111, 3'b011, 5, 9, 0, 1'b0, 1'b0);
        chk("empty_cnt", s_cnt, 0);
        chk("empty_avail", s_avail, 0);
        chk("empty_ok", int'(s_ok), 0);
        step(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("refill_ok", int'(s_ok), 3);
        chk("refill_tag0", s_tag[0], 5);
        chk("refill_tag1", s_tag[1], 9);
        chk("refill_tag2", s_tag[2], 0);

        // Recovery after 10 allocations and 4 frees.
        step(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b1);
        step(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("post_rst_cnt", s_cnt, 32);
        step(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        step(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        step(3'b001, 3'b111, 50, 51, 52, 1'b0, 1'b0);
        step(3'b000, 3'b001, 53, 0, 0, 1'b0, 1'b0);
        step(3'b000, 3'b001, 12, 0, 0, 1'b1, 1'b0);
        chk("pre_rec_cnt", s_cnt, 26);
        step(3'b000, 3'b001, 7, 0, 0, 1'b0, 1'b0);
        chk("rec_cnt", s_cnt, 32);
        chk("pre_ovf_err", int'(s_err), 0);
        step(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0);
        chk("ovf_err", int'(s_err), 1);
        chk("ovf_cnt", s_cnt, 32);
        for (int i = 0; i < 10; i++) step(3'b111, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("err_after_rec", int'(s_err), 1);
        step(3'b011, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("wrap_ok", int'(s_ok), 3);
        chk("wrap_tag0", s_tag[0], 53);
        chk("rec_written_tag", s_tag[1], 12);

        // Mixed random traffic with occasional recovery; pointers straddle the wrap often.
        for (int n = 0; n < 300; n++) begin
            ra = 3'($urandom_range(0, 7));
            rf = (m_cnt <= DEPTH - 3) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(ra, rf, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                 ($urandom_range(0, 19) == 0), 1'b0);
        end

        // Reset mid-operation discards that cycle's traffic and clears the error flag.
        step(3'b111, 3'b111, 1, 2, 3, 1'b0, 1'b1);
        step(3'b001, 3'b000, 0, 0, 0, 1'b0, 1'b0);
        chk("rst_cnt", s_cnt, 32);
        chk("rst_err", int'(s_err), 0);
        chk("rst_tag0", s_tag[0], 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
